// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered results and an iterative
// shift-add multiplier. One op in flight; the output register is held
// under backpressure and tracked by out_valid independently of the FSM.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    F_ADD  = 4'b0000, F_SUB  = 4'b0001, F_SLT  = 4'b0010, F_SLTU = 4'b0011,
    F_SLL  = 4'b0100, F_SRL  = 4'b0101, F_ROL  = 4'b0110, F_ROR  = 4'b0111,
    F_AND  = 4'b1000, F_OR   = 4'b1001, F_XOR  = 4'b1010, F_NOR  = 4'b1011,
    F_NAND = 4'b1100, F_XNOR = 4'b1101, F_SRA  = 4'b1110, F_MUL  = 4'b1111
  } func_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   sub_x;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH-1:0] acc_sum;

  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out       = out_q;
  assign flags     = flags_q;
  assign out_valid = out_valid_q;

  // Single-cycle ALU result and carry/overflow for every non-MUL op
  always_comb begin
    shamt   = b[SHW-1:0];
    add_x   = {1'b0, a} + {1'b0, b};
    sub_x   = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (func_e'(func))
      F_ADD: begin
        alu_res = add_x[WIDTH-1:0];
        alu_c   = add_x[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_x[WIDTH-1] != a[WIDTH-1]);
      end
      F_SUB: begin
        alu_res = sub_x[WIDTH-1:0];
        alu_c   = ~sub_x[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_x[WIDTH-1] != a[WIDTH-1]);
      end
      F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      F_SLL:  alu_res = a << shamt;
      F_SRL:  alu_res = a >> shamt;
      // shift by WIDTH yields 0, so amount 0 degenerates cleanly to a
      F_ROL:  alu_res = (a << shamt) | (a >> (WIDTH - int'(shamt)));
      F_ROR:  alu_res = (a >> shamt) | (a << (WIDTH - int'(shamt)));
      F_AND:  alu_res = a & b;
      F_OR:   alu_res = a | b;
      F_XOR:  alu_res = a ^ b;
      F_NOR:  alu_res = ~(a | b);
      F_NAND: alu_res = ~(a & b);
      F_XNOR: alu_res = ~(a ^ b);
      F_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Multiplier partial-sum for the current iteration
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state: accept, multiply iteration and output-register handshake
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !out_ready;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (func_e'(func) == F_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else begin
            out_d       = alu_res;
            flags_d     = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            out_valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          out_d       = acc_sum;
          flags_d     = {acc_sum[WIDTH-1], (acc_sum == '0), 2'b00};
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes hand-computed {out,flags}
// on acceptance, monitor pops and compares on every output handoff.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  func;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [3:0]  flags;

  int errors = 0;
  int checks = 0;

  logic [35:0] exp_q[$];
  string       name_q[$];

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .func      (func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input string nm, input logic [3:0] f, input logic [31:0] ia,
                       input logic [31:0] ib, input logic [31:0] eo, input logic [3:0] ef);
    bit done = 0;
    in_valid = 1'b1;
    func     = f;
    a        = ia;
    b        = ib;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({eo, ef});
        name_q.push_back(nm);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout_%s: got no in_ready expected acceptance", nm);
    end
  endtask

  // Waits for a MUL result, checking latency and in_ready low meanwhile
  task automatic wait_mul(input string nm);
    int  cyc = 0;
    bit  rdy_seen = 0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) rdy_seen = 1;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({nm, "_latency"}, cyc, 32);
    check({nm, "_in_ready_low"}, rdy_seen, 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each result on the cycle it is handed off
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_result: got %h/%h expected none", out, flags);
      end else begin
        check(name_q.pop_front(), {out, flags}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    func      = '0;
    #1;
    check("rst_out", out, 0);
    check("rst_flags", flags, 0);
    check("rst_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", in_ready, 1);

    issue("add_wrap", 4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0110);
    check("add_latency", out_valid, 1);
    issue("sub_ovf", 4'b0001, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0011);
    issue("slt", 4'b0010, 32'hFFFFFFFF, 32'h1, 32'h1, 4'b0000);
    issue("sltu", 4'b0011, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0100);

    issue("sll4", 4'b0100, 32'h80000001, 32'd4, 32'h00000010, 4'b0000);
    issue("srl4", 4'b0101, 32'h80000001, 32'd4, 32'h08000000, 4'b0000);
    issue("sra4", 4'b1110, 32'h80000001, 32'd4, 32'hF8000000, 4'b1000);
    issue("rol4", 4'b0110, 32'h80000001, 32'd4, 32'h00000018, 4'b0000);
    issue("ror4", 4'b0111, 32'h80000001, 32'd4, 32'h18000000, 4'b0000);
    issue("sll0", 4'b0100, 32'h80000001, 32'd32, 32'h80000001, 4'b1000);
    issue("srl0", 4'b0101, 32'h80000001, 32'd32, 32'h80000001, 4'b1000);
    issue("sra0", 4'b1110, 32'h80000001, 32'd32, 32'h80000001, 4'b1000);
    issue("rol0", 4'b0110, 32'h80000001, 32'd32, 32'h80000001, 4'b1000);
    issue("ror0", 4'b0111, 32'h80000001, 32'd32, 32'h80000001, 4'b1000);

    issue("and", 4'b1000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000);
    issue("or", 4'b1001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 4'b1000);
    issue("xor", 4'b1010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000);
    issue("nor", 4'b1011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 4'b0000);
    issue("nand", 4'b1100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 4'b0000);
    issue("xnor", 4'b1101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 4'b1000);

    issue("mul_shift", 4'b1111, 32'h00012345, 32'h100, 32'h01234500, 4'b0000);
    wait_mul("mul_shift");
    issue("mul_neg", 4'b1111, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 4'b1000);
    wait_mul("mul_neg");

    // Backpressure: AND held, then XOR handed in on the draining edge
    out_ready = 1'b0;
    issue("bp_and", 4'b1000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_out", out, 32'hF000F000);
      check("bp_in_ready_low", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    issue("b2b_xor", 4'b1010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000);
    check("b2b_valid_stays", out_valid, 1);
    check("b2b_out", out, 32'h0FF00FF0);
    @(posedge clk);
    #1;

    // Reset while a result is held
    out_ready = 1'b0;
    issue("held_or", 4'b1001, 32'h1, 32'h2, 32'h3, 4'b0000);
    #2 rst_n = 1'b0;
    exp_q.delete();
    name_q.delete();
    #1;
    check("midrst_out", out, 0);
    check("midrst_flags", flags, 0);
    check("midrst_valid", out_valid, 0);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Reset during MUL iteration 10
    issue("mul_abort", 4'b1111, 32'd5, 32'd7, 32'd35, 4'b0000);
    check("mul_busy", in_ready, 0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    name_q.delete();
    #1;
    check("mulrst_valid", out_valid, 0);
    check("mulrst_idle", in_ready, 1);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue("add_after_rst", 4'b0000, 32'd2, 32'd3, 32'd5, 4'b0000);
    check("add_after_rst_latency", out_valid, 1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("queue_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
